// File: rtl/demux1_4_rr_ctrl.sv
// demux1_4_rr_ctrl
// Round-robin dispatcher for a 1-to-4 demultiplexer. Registers one word from
// a valid/ready input, presents it to one enabled destination chosen in
// rotating order, holds it until that destination accepts, and counts
// completed deliveries. A delivery and a new accept may share a cycle, so a
// continuously ready destination sees one word per cycle.

module demux1_4_rr_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [3:0]   en,
    output logic [3:0]   sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data,
    output logic [15:0]  xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Rotate a one-hot destination vector by one position towards bit 3,
    // wrapping destination 3 back to destination 0.
    function automatic logic [3:0] rotl1(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

    // First enabled destination found by searching base, rotl(base,1),
    // rotl(base,2), rotl(base,3). Returns 4'b0000 when mask is empty.
    function automatic logic [3:0] pick_target(input logic [3:0] base,
                                               input logic [3:0] mask);
        logic [3:0] cand;
        logic [3:0] result;
        cand   = base;
        result = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if ((result == 4'b0000) && ((cand & mask) != 4'b0000)) begin
                result = cand;
            end
            cand = rotl1(cand);
        end
        return result;
    endfunction

    state_t         state;
    state_t         state_next;
    logic [3:0]     ptr;
    logic [3:0]     ptr_next;
    logic [3:0]     sel_next;
    logic [W-1:0]   data_next;
    logic [15:0]    cnt_next;

    logic           any_en;
    logic           delivery;
    logic           accept;
    logic [3:0]     search_base;
    logic [3:0]     pick;

    // Handshake decode: a held word is delivered only through its own select
    // line; ready bits of other destinations are ignored. in_ready is gated by
    // rst_n so nothing is taken while reset is asserted.
    always_comb begin
        any_en      = |en;
        delivery    = (state == BUSY) && ((out_ready & sel) != 4'b0000);
        if (state == BUSY) begin
            in_ready = rst_n && delivery && any_en;
        end else begin
            in_ready = rst_n && any_en;
        end
        accept      = in_valid && in_ready;
        // While BUSY the next search starts after the destination just served,
        // which is the value ptr is about to take, not the stale ptr.
        search_base = (state == BUSY) ? rotl1(sel) : ptr;
        pick        = pick_target(search_base, en);
    end

    // Next-state and next-register values for the dispatcher FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        data_next  = out_data;
        cnt_next   = xfer_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    data_next  = in_data;
                    sel_next   = pick;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (delivery) begin
                    ptr_next = rotl1(sel);
                    cnt_next = xfer_cnt + 16'd1;
                    if (accept) begin
                        data_next  = in_data;
                        sel_next   = pick;
                        state_next = BUSY;
                    end else begin
                        sel_next   = 4'b0000;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                sel_next   = 4'b0000;
                state_next = IDLE;
            end
        endcase
    end

    // State register: async reset drops any held word without counting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 4'b0001;
            sel      <= 4'b0000;
            out_data <= '0;
            xfer_cnt <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_next;
            ptr      <= ptr_next;
            sel      <= sel_next;
            out_data <= data_next;
            xfer_cnt <= cnt_next;
        end
    end

    // Per-destination valid mirrors the registered one-hot select.
    always_comb begin
        out_valid = sel;
    end

endmodule

// File: tb/tb_demux1_4_rr_ctrl.sv
// tb_demux1_4_rr_ctrl
// Self-checking bench: a directed vector table, hand-written corner
// sequences (en change while busy, en=0, reset mid-transfer, counter wrap)
// and a randomized run, all compared against a behavioural model that
// tracks destinations as integer indices.

module tb_demux1_4_rr_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [3:0]   en;
    logic [3:0]   sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data;
    logic [15:0]  xfer_cnt;

    demux1_4_rr_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .en        (en),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: destinations as indices 0..3.
    bit          m_held;
    int          m_idx;
    int          m_ptr;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input int start, input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_held = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_data = 8'h00;
        m_cnt  = 16'h0000;
    endtask

    // One clock cycle, entered and left at a falling edge: drive inputs,
    // compare DUT outputs against the model, then advance the model.
    task automatic step(input logic iv, input logic [7:0] d, input logic [3:0] e,
                        input logic [3:0] ordy);
        logic       exp_rdy;
        logic       deliv;
        logic [3:0] exp_sel;
        in_valid  = iv;
        in_data   = d;
        en        = e;
        out_ready = ordy;
        #1;
        deliv   = m_held && ordy[m_idx];
        exp_rdy = m_held ? (deliv && (e != 4'b0000)) : (e != 4'b0000);
        exp_sel = m_held ? onehot(m_idx) : 4'b0000;
        check("model_sel", 32'(sel), 32'(exp_sel));
        check("model_out_valid", 32'(out_valid), 32'(exp_sel));
        check("model_out_data", 32'(out_data), 32'(m_data));
        check("model_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        check("model_in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (deliv) begin
            m_cnt = m_cnt + 16'd1;
            m_ptr = (m_idx + 1) % 4;
            m_held = 1'b0;
        end
        if (iv && exp_rdy) begin
            m_held = 1'b1;
            m_idx  = model_pick(m_ptr, e);
            m_data = d;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        iv;
        logic [7:0]  din;
        logic [3:0]  en;
        logic [3:0]  ordy;
        logic [3:0]  sel;
        logic        rdy;
        logic [7:0]  data;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // Full rotation: eight words back to back, then drain.
        vecs[0]  = '{1'b1, 8'hA0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 8'h00, 16'd0};
        vecs[1]  = '{1'b1, 8'hA1, 4'b1111, 4'b1111, 4'b0001, 1'b1, 8'hA0, 16'd0};
        vecs[2]  = '{1'b1, 8'hA2, 4'b1111, 4'b1111, 4'b0010, 1'b1, 8'hA1, 16'd1};
        vecs[3]  = '{1'b1, 8'hA3, 4'b1111, 4'b1111, 4'b0100, 1'b1, 8'hA2, 16'd2};
        vecs[4]  = '{1'b1, 8'hA4, 4'b1111, 4'b1111, 4'b1000, 1'b1, 8'hA3, 16'd3};
        vecs[5]  = '{1'b1, 8'hA5, 4'b1111, 4'b1111, 4'b0001, 1'b1, 8'hA4, 16'd4};
        vecs[6]  = '{1'b1, 8'hA6, 4'b1111, 4'b1111, 4'b0010, 1'b1, 8'hA5, 16'd5};
        vecs[7]  = '{1'b1, 8'hA7, 4'b1111, 4'b1111, 4'b0100, 1'b1, 8'hA6, 16'd6};
        vecs[8]  = '{1'b0, 8'h00, 4'b1111, 4'b1111, 4'b1000, 1'b1, 8'hA7, 16'd7};
        // Masked skip with en=1010.
        vecs[9]  = '{1'b1, 8'hB0, 4'b1010, 4'b1111, 4'b0000, 1'b1, 8'hA7, 16'd8};
        vecs[10] = '{1'b1, 8'hB1, 4'b1010, 4'b1111, 4'b0010, 1'b1, 8'hB0, 16'd8};
        vecs[11] = '{1'b1, 8'hB2, 4'b1010, 4'b1111, 4'b1000, 1'b1, 8'hB1, 16'd9};
        vecs[12] = '{1'b1, 8'hB3, 4'b1010, 4'b1111, 4'b0010, 1'b1, 8'hB2, 16'd10};
        vecs[13] = '{1'b0, 8'h00, 4'b1010, 4'b1111, 4'b1000, 1'b1, 8'hB3, 16'd11};
        // Backpressure: 5A held at destination 0 for three stalled cycles.
        vecs[14] = '{1'b1, 8'h5A, 4'b1111, 4'b1110, 4'b0000, 1'b1, 8'hB3, 16'd12};
        vecs[15] = '{1'b0, 8'h00, 4'b1111, 4'b1110, 4'b0001, 1'b0, 8'h5A, 16'd12};
        vecs[16] = '{1'b0, 8'h00, 4'b1111, 4'b1110, 4'b0001, 1'b0, 8'h5A, 16'd12};
        vecs[17] = '{1'b0, 8'h00, 4'b1111, 4'b1110, 4'b0001, 1'b0, 8'h5A, 16'd12};
        vecs[18] = '{1'b0, 8'h00, 4'b1111, 4'b0001, 4'b0001, 1'b1, 8'h5A, 16'd12};
        vecs[19] = '{1'b0, 8'h00, 4'b1111, 4'b0000, 4'b0000, 1'b1, 8'h5A, 16'd13};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        en        = 4'b0000;
        out_ready = 4'b0000;
        model_reset();

        // Reset state.
        #2;
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);
        check("reset_xfer_cnt", 32'(xfer_cnt), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 20; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            en        = vecs[i].en;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
            step(vecs[i].iv, vecs[i].din, vecs[i].en, vecs[i].ordy);
        end

        // en change while BUSY: word stays bound to destination 2.
        step(1'b1, 8'hC0, 4'b0100, 4'b0000);
        check("enchg_held_sel", 32'(sel), 32'h4);
        step(1'b0, 8'h00, 4'b0001, 4'b1011);
        check("enchg_still_sel", 32'(sel), 32'h4);
        step(1'b1, 8'hC1, 4'b0001, 4'b0100);
        check("enchg_next_sel", 32'(sel), 32'h1);
        check("enchg_next_data", 32'(out_data), 32'hC1);
        step(1'b0, 8'h00, 4'b0001, 4'b1111);

        // en=0: nothing accepted.
        in_valid = 1'b1;
        en       = 4'b0000;
        #1;
        check("en0_in_ready", 32'(in_ready), 32'h0);
        step(1'b1, 8'hEE, 4'b0000, 4'b1111);
        check("en0_no_accept", 32'(sel), 32'h0);

        // Reset mid-transfer with destination 2 held.
        step(1'b1, 8'h77, 4'b0100, 4'b0000);
        step(1'b0, 8'h00, 4'b0100, 4'b0000);
        check("rstmid_held_sel", 32'(sel), 32'h4);
        in_valid  = 1'b1;
        en        = 4'b1111;
        out_ready = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_sel", 32'(sel), 32'h0);
        check("rstmid_out_valid", 32'(out_valid), 32'h0);
        check("rstmid_out_data", 32'(out_data), 32'h0);
        check("rstmid_xfer_cnt", 32'(xfer_cnt), 32'h0);
        check("rstmid_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 8'h11, 4'b1111, 4'b0000);
        check("rstmid_first_dest0", 32'(sel), 32'h1);
        step(1'b0, 8'h00, 4'b1111, 4'b1111);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
                 4'($urandom));
        end

        // Counter wrap with a single-destination mask.
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 8'(i), 4'b0100, 4'b1111);
        end
        check("wrap_pre_cnt", 32'(xfer_cnt), 32'hFFFF);
        check("wrap_single_dest", 32'(sel), 32'h4);
        step(1'b0, 8'h00, 4'b0100, 4'b1111);
        check("wrap_cnt_zero", 32'(xfer_cnt), 32'h0);
        check("wrap_idle_sel", 32'(sel), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1_4_rr_ctrl.md
# demux1_4_rr_ctrl

Round-robin dispatcher that sequences the 1-to-4 demultiplexer datapath. It accepts a word stream on a single valid/ready input and registers each word. It drives the one-hot demux select and routes each word to one of four destinations in rotating order, skipping disabled destinations. It holds each word until the selected destination accepts it, and counts completed deliveries.

## Interface
- W, 8: data width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  controller accepts upstream word this cycle.
- in_data  input  W  upstream word.
- en  input  4  destination enable mask; bit k enables destination k.
- sel  output  4  one-hot demux select for the held word; 4'b0000 when nothing is held.
- out_valid  output  4  per-destination valid; equals sel.
- out_ready  input  4  per-destination ready.
- out_data  output  W  registered word, shared by all destinations.
- xfer_cnt  output  16  count of completed deliveries; wraps modulo 2^16.

## Operation
- Internal one-hot pointer ptr. It marks the destination searched first.
- Target pick: search ptr, rotl(ptr,1), rotl(ptr,2), rotl(ptr,3) in that order. Take the first with its en bit set.
- If en==4'b0000, no target exists and the controller does not accept input.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - sel=0, out_valid=0.
  - in_ready = |en.
  - On in_valid & in_ready: out_data<=in_data, sel<=pick, go to BUSY.
- BUSY:
  - out_valid=sel; out_data and sel are held stable.
  - Delivery occurs when |(out_ready & sel).
  - On delivery: ptr<=rotl(sel,1), xfer_cnt<=xfer_cnt+1.
  - in_ready = delivery & |en. This is combinational from out_ready and en.
  - Delivery with in_valid & in_ready: load the new word. New sel = pick computed from rotl(sel,1), not the old ptr. Stay in BUSY.
  - Delivery without a new accept: sel<=0, go to IDLE.
  - No delivery: hold everything.
- en changing while BUSY does not reroute the held word. It stays bound to its sel until delivered, even if that destination's en bit drops. en only affects the next pick.
- out_ready bits outside sel are ignored.
- xfer_cnt wraps from 16'hFFFF to 16'h0000 with no flag.

## Timing
- Reset (async assert, sync release): state=IDLE, ptr=4'b0001, sel=4'b0000, out_valid=4'b0000, out_data=0, xfer_cnt=0.
- in_ready is forced 0 while rst_n is low.
- A word held when reset asserts is discarded and not counted.
- Latency: a word accepted in cycle N is presented (out_valid set) in cycle N+1.
- Throughput: one word per cycle when the selected destination's out_ready is high continuously.
- Back-to-back delivery plus accept leaves no bubble.
- A single-destination mask (e.g. en=4'b0100) sends every word to destination 2.
- Pointer wrap: after a delivery to destination 3, the next search starts at destination 0.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-transfer with sel=4'b0100 held.
  - Required: sel, out_valid, out_data and xfer_cnt read 0 immediately; in_ready=0.
  - After release: first word goes to destination 0.
- Full rotation:
  - Stimulus: en=4'b1111, out_ready=4'b1111; stream words 8'hA0..8'hA7 on consecutive cycles.
  - Required: sel sequence 0001,0010,0100,1000,0001,0010,0100,1000 on consecutive cycles; xfer_cnt=8.
- Masked skip:
  - Stimulus: en=4'b1010, out_ready=4'b1111; send 4 words.
  - Required: sel=0010,1000,0010,1000.
- Backpressure:
  - Stimulus: word 8'h5A targeted at sel=0001; hold out_ready=4'b1110 for 3 cycles, then 4'b0001.
  - Required: out_data=8'h5A and sel=0001 stable all 4 cycles; in_ready=0 for 3 cycles, then 1 in the delivery cycle.
- en change while BUSY:
  - Stimulus: word held at sel=0100; drop en to 4'b0001 before delivery.
  - Required: the word is still delivered to destination 2; the next word goes to destination 0.
  - Stimulus: en=0.
  - Required: in_ready=0 and no accept.
- Counter wrap:
  - Stimulus: preload by delivering 65536 words.
  - Required: xfer_cnt returns to 16'h0000.
